// File: rtl/nibble_pack_ctrl.sv
// nibble_pack_ctrl: pairs incoming 4-bit nibbles into bytes in a selectable
// order, with partial-pair flush and a single registered output slot.
module nibble_pack_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] nib_in,
   input  logic       nib_valid,
   output logic       nib_ready,
   input  logic [1:0] mode,
   input  logic       flush,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic [7:0] byte_cnt,
   output logic       half
);

   localparam int unsigned NIB_W  = 4;
   localparam int unsigned BYTE_W = 8;
   localparam logic [NIB_W-1:0] PAD = 4'h0;

   typedef enum logic {
      EMPTY = 1'b0,
      HALF  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [NIB_W-1:0]    n0_q, n0_d;
   logic [1:0]          mode_q, mode_d;
   logic [BYTE_W-1:0]   byte_out_q, byte_out_d;
   logic                byte_valid_q, byte_valid_d;
   logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;

   logic nib_ready_c;
   logic out_free_c;
   logic nib_acc_c;
   logic out_acc_c;

   // Concatenation order; mode 11 is reserved and aliases mode 00.
   function automatic logic [BYTE_W-1:0] pack(input logic [NIB_W-1:0] a,
                                              input logic [NIB_W-1:0] b,
                                              input logic [1:0]       m);
      case (m)
         2'b01:   pack = {b, a};
         2'b10:   pack = {a, a};
         default: pack = {a, b};
      endcase
   endfunction

   // Handshake qualifiers; ready depends only on state and the output slot.
   always_comb begin
      out_free_c  = !byte_valid_q || byte_ready;
      nib_ready_c = (state_q == EMPTY) || out_free_c;
      nib_acc_c   = nib_valid && nib_ready_c;
      out_acc_c   = byte_valid_q && byte_ready;
   end

   // Next-state: pairing, flush, output slot load/drain and hand-off count.
   always_comb begin
      state_d      = state_q;
      n0_d         = n0_q;
      mode_d       = mode_q;
      byte_out_d   = byte_out_q;
      byte_valid_d = byte_valid_q;
      byte_cnt_d   = byte_cnt_q;

      if (out_acc_c) begin
         byte_valid_d = 1'b0;
         byte_cnt_d   = BYTE_W'(byte_cnt_q + 8'd1);
      end

      case (state_q)
         EMPTY: begin
            if (nib_acc_c) begin
               n0_d    = nib_in;
               mode_d  = mode;
               state_d = HALF;
            end
         end
         HALF: begin
            if (nib_acc_c) begin
               byte_out_d   = pack(n0_q, nib_in, mode_q);
               byte_valid_d = 1'b1;
               state_d      = EMPTY;
            end else if (flush && !nib_valid && out_free_c) begin
               byte_out_d   = pack(n0_q, PAD, mode_q);
               byte_valid_d = 1'b1;
               state_d      = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= EMPTY;
         n0_q         <= '0;
         mode_q       <= 2'b00;
         byte_out_q   <= '0;
         byte_valid_q <= 1'b0;
         byte_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         n0_q         <= n0_d;
         mode_q       <= mode_d;
         byte_out_q   <= byte_out_d;
         byte_valid_q <= byte_valid_d;
         byte_cnt_q   <= byte_cnt_d;
      end
   end

   assign nib_ready  = nib_ready_c;
   assign byte_out   = byte_out_q;
   assign byte_valid = byte_valid_q;
   assign byte_cnt   = byte_cnt_q;
   assign half       = (state_q == HALF);

endmodule

// File: doc/nibble_pack_ctrl.md
# nibble_pack_ctrl

Sequencing controller for the concatenation datapath: collects a stream of 4-bit nibbles, pairs them, and emits 8-bit concatenated bytes in a selectable packing order over a valid/ready handshake. It sits between a nibble-wide producer and a byte-wide consumer. It owns pairing state, ordering mode, partial-pair flush and output buffering, so the concatenation logic stays purely combinational inside it.

## Interface
- PAD, 4'h0, nibble used to complete a half-filled pair on flush
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- nib_in  in  4  input nibble
- nib_valid  in  1  nib_in is valid
- nib_ready  out  1  block accepts nib_in this cycle
- mode  in  2  packing order, sampled when the first nibble of a pair is accepted
- flush  in  1  request to close a half-filled pair using PAD
- byte_out  out  8  packed byte
- byte_valid  out  1  byte_out is valid
- byte_ready  in  1  consumer accepts byte_out
- byte_cnt  out  8  count of bytes handed off, wraps 255→0
- half  out  1  one nibble held, awaiting its partner

## Operation
- States: EMPTY (no nibble held), HALF (n0 and mode_q held). The output register (byte_out/byte_valid) is separate from the pairing state.
- Nibble accept: nib_acc = nib_valid & nib_ready. Out handshake: out_acc = byte_valid & byte_ready.
- nib_ready = 1 in EMPTY. In HALF it is !byte_valid | byte_ready, so a second nibble is taken only if the output register is free or draining in the same cycle.
- EMPTY + nib_acc: n0 ← nib_in, mode_q ← mode, go to HALF.
- HALF + nib_acc: load the output register with pack(n0, nib_in, mode_q), set byte_valid, go to EMPTY.
- pack(n0,n1,m):
  - m=00: {n0,n1}
  - m=01: {n1,n0}
  - m=10: {n0,n0}; n1 is consumed and discarded
  - m=11: reserved, behaves as 00
- Flush: in HALF with flush=1, nib_valid=0, and the output register free or draining, load pack(n0, PAD, mode_q), set byte_valid, go to EMPTY.
- Flush in EMPTY: no effect.
- Flush in HALF while the output is blocked: no effect that cycle. Flush is level-sensitive; the producer holds it until half deasserts.
- Simultaneous flush and nib_acc in HALF: the nibble wins and flush is ignored. The pair completes normally.
- out_acc without a new load: byte_valid ← 0.
- out_acc with a load in the same cycle: byte_valid stays 1 and byte_out takes the new value.
- byte_cnt increments by 1 on every out_acc, modulo 256.
- half = (state == HALF).
- mode changes while in HALF do not affect the pending pair.

## Timing
- Reset (rst=1 at a clk edge):
  - state ← EMPTY
  - byte_valid ← 0, byte_out ← 8'h00, byte_cnt ← 8'h00
  - n0 ← 0, mode_q ← 00
  - Reset mid-pair discards the held nibble. Reset with byte_valid=1 drops the byte without counting it.
- Outputs after reset release: nib_ready=1, half=0.
- Latency: byte_valid rises the cycle after the second nibble (or flush) is accepted.
- Throughput: with byte_ready held high, one byte every 2 cycles, i.e. one nibble per cycle.
- Backpressure: byte_out and byte_valid hold stable while byte_valid=1 & byte_ready=0.
- nib_ready is combinational from state, byte_valid and byte_ready. All other outputs are registered.
- No combinational path from nib_valid to nib_ready.

## Test plan
- Basic order: reset; mode=00; feed 4'h3, 4'h5; byte_ready=1.
  - Expect byte_out=8'h35 and byte_valid=1 one cycle after the 2nd accept; byte_cnt=1.
- Mode variants: mode=01, feed F,A → 8'hAF. Mode=10, feed 6,D → 8'h66. Mode=11, feed 6,D → 8'h6D.
  - Also change mode to 01 between nibbles of a mode=00 pair: result is still {n0,n1}.
- Backpressure: byte_ready=0; feed 1,2 then 3.
  - Expect 8'h12 held stable; 3 accepted into HALF; nib_ready=0 for the 4th nibble.
  - Raise byte_ready: the 4th nibble is accepted in the same cycle, and the next byte appears without a bubble.
- Flush: PAD=4'h0, mode=00; feed 9, then flush=1 with nib_valid=0 → byte_out=8'h90, half=0.
  - Flush in EMPTY → no output.
  - Flush together with nib_valid (nibble 4) in HALF → byte 8'h94.
- Counter wrap: stream 256 bytes with byte_ready=1.
  - byte_cnt returns to 8'h00 after the 256th handshake.
- Reset mid-operation: assert rst in HALF with byte_valid=1 and byte_ready=0.
  - Next cycle: byte_valid=0, half=0, byte_cnt=0, byte_out=8'h00.
  - Subsequent nibbles 7,8 → 8'h78.
